bitbang_sample: RTL
===================

# bitbang_sample

Input-side companion to the bitbang pad controller: samples the `IO_NUM_OF` bitbang pins, synchronizes them to the system clock and detects per-pin rising/falling edges under software-programmable masks. Each qualifying change is timestamped and queued as an event record in a small FIFO. The controller drains the FIFO through a valid/ready handshake. The block sits between the pad ring, which it observes read-only, and the controller interface.

## Interface
- `IO_NUM_OF`, 10: number of sampled pins.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two, ≥2.
- `TS_WIDTH`, 16: timestamp counter width.
- `DEBOUNCE_CYCLES`, 8: consecutive stable samples required; used only with the debounce feature.
- `in_clk`  input  1: system clock; all logic on its rising edge.
- `in_rst_n`  input  1: asynchronous, active-low reset.
- `in_io_pins`  input  IO_NUM_OF: raw pin levels, asynchronous to `in_clk`.
- `in_rise_en`  input  IO_NUM_OF: per-pin rising-edge event enable.
- `in_fall_en`  input  IO_NUM_OF: per-pin falling-edge event enable.
- `in_ovf_clr`  input  1: single-cycle pulse that clears `out_overflow`.
- `out_evt_valid`  output  1: FIFO non-empty.
- `in_evt_ready`  input  1: controller pops the head entry when valid and ready are both high.
- `out_evt_pins`  output  IO_NUM_OF: pin snapshot of the head event.
- `out_evt_ts`  output  TS_WIDTH: timestamp of the head event.
- `out_pins_sync`  output  IO_NUM_OF: current synchronized (or debounced) pin levels.
- `out_overflow`  output  1: sticky flag, set when an event is dropped.

## Operation
- Per pin: 2-flop synchronizer, then `prev` register. `edge_r = cur & ~prev & in_rise_en`. `edge_f = ~cur & prev & in_fall_en`.
- An event fires when any bit of `edge_r | edge_f` is set. One FIFO record `{cur[IO_NUM_OF-1:0], ts}` is written per cycle, regardless of how many pins changed.
- Masks are evaluated in the detection cycle. Toggling a mask never creates a synthetic event.
- `ts` is a free-running counter that increments every cycle and wraps from 2^TS_WIDTH−1 to 0. The record captures the counter value of the detection cycle.
- Warm-up: a 2-bit counter suppresses detection for the first 3 cycles after reset release. During warm-up, `prev` tracks `cur`, so the pin levels present at reset generate no events.
- FIFO behaviour:
  - Push when an event fires and (not full, or a pop happens in the same cycle).
  - Event while full with no pop: the event is dropped, the FIFO is unchanged and `out_overflow` is set.
  - Simultaneous set and `in_ovf_clr`: set wins.
  - Push and pop in the same cycle with the FIFO empty: the pop is ignored because valid is low, and the push proceeds.
- `out_evt_*` present the head entry combinationally from FIFO storage. They are undefined (do not care) while `out_evt_valid` = 0.

## Timing
- All outputs reset to 0: `out_evt_valid`, `out_evt_pins`, `out_evt_ts`, `out_pins_sync`, `out_overflow`. Synchronizer, `prev`, `ts`, pointers and warm-up counter also reset to 0.
- Without debounce, a pin change first sampled at edge N:
  - sync1 updates at N and `cur` at N+1, so `out_pins_sync` is valid after N+1.
  - Detection occurs in cycle N+1→N+2.
  - FIFO write happens at edge N+2, so `out_evt_valid` is high after N+2.
- A pop at edge M makes the next entry (or valid = 0) visible after M.
- Full throughput: one push and one pop per cycle.
- Reset asserted mid-operation: all state is cleared immediately, queued events are lost and warm-up restarts.

## Configuration
- `BITBANG_SAMPLE_DEBOUNCE_EN` defined:
  - Each pin has a counter between sync2 and `cur`. `cur` updates only after sync2 has differed from `cur` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce back to the `cur` level resets that pin's counter.
  - Adds `DEBOUNCE_CYCLES` cycles of latency.
- Undefined: `cur` = sync2 and no counters are instantiated; `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `bitbang_pkg`: event record width constant (`IO_NUM_OF + TS_WIDTH`), warm-up length constant (3), FIFO pointer-width function (clog2).
- Sub-module `io_sync_bit`: one per pin, instantiated as an array. It contains the 2-flop synchronizer and the optional debounce counter, and outputs `cur`. Edge detection, timestamp and FIFO live in the top.

## Test plan
- Reset with `in_io_pins` = 10'h3FF, masks all 1, release → no event after 10 cycles, `out_pins_sync` = 10'h3FF.
- Pin 0 rises 0→1 with `in_rise_en[0]`=1, `in_evt_ready`=0 → `out_evt_valid` high 3 edges after sampling, `out_evt_pins[0]`=1, `out_evt_ts` = detection-cycle count.
- Pins 2 and 5 fall in the same cycle, only `in_fall_en[5]`=1 → exactly one record with both bits 0. Repeat with both masks 0 → no record.
- With `in_evt_ready`=0, 5 separate enabled edges into a depth-4 FIFO → 4 records retained in order, `out_overflow`=1. `in_ovf_clr` pulse → flag clears. Then drain 4 → valid = 0.
- FIFO full, event and pop in the same cycle → occupancy stays 4, `out_overflow` stays 0, new record at the tail.
- With `BITBANG_SAMPLE_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=8: 5-cycle glitch → no event. 8-cycle-stable change → one event, 8 cycles later than in the non-debounce build.

Source files
------------

// File: rtl/bitbang_pkg.sv
// rtl/bitbang_pkg.sv - shared constants and helpers for the bitbang pin sampler
package bitbang_pkg;

  // Default pin count and timestamp width of the sampler
  localparam int IO_NUM_OF_DEFAULT = 10;
  localparam int TS_WIDTH_DEFAULT  = 16;

  // One event record is {pin snapshot, timestamp}
  localparam int EVT_WIDTH = IO_NUM_OF_DEFAULT + TS_WIDTH_DEFAULT;

  // Cycles after reset release during which edge detection is suppressed
  localparam int WARMUP_CYCLES = 3;

  // Event record width for an arbitrary configuration
  function automatic int evt_width(input int io_num, input int ts_width);
    return io_num + ts_width;
  endfunction

  // FIFO address width; a wrap bit is added on top by the user
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/io_sync_bit.sv
// rtl/io_sync_bit.sv - per-pin 2-flop synchronizer with optional debounce (BITBANG_SAMPLE_DEBOUNCE_EN)
module io_sync_bit #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_pin,
  input  logic in_warm,
  output logic out_cur
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-stage synchronizer next state
  always_comb begin
    sync1_d = in_pin;
    sync2_d = sync1_q;
  end

  // Synchronizer flops
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef BITBANG_SAMPLE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce: accept a new level only after it has held for DEBOUNCE_CYCLES samples;
  // during warm-up follow the synchronizer so the reset-time level is not an event
  always_comb begin
    cur_d = cur_q;
    cnt_d = '0;
    if (in_warm) begin
      cur_d = sync2_d;
    end else if (sync2_q != cur_q) begin
      if (cnt_q == CNT_LAST) begin
        cur_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounced level and stability counter
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cur_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_cur = cur_q;
`else
  logic unused_cfg;
  assign unused_cfg = in_warm & (DEBOUNCE_CYCLES > 0);
  assign out_cur    = sync2_q;
`endif

endmodule

// File: rtl/bitbang_sample.sv
// rtl/bitbang_sample.sv - bitbang pin edge sampler with timestamped event FIFO (option: BITBANG_SAMPLE_DEBOUNCE_EN)
module bitbang_sample
  import bitbang_pkg::*;
#(
  parameter int IO_NUM_OF       = IO_NUM_OF_DEFAULT,
  parameter int FIFO_DEPTH      = 4,
  parameter int TS_WIDTH        = TS_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [IO_NUM_OF-1:0] in_io_pins,
  input  logic [IO_NUM_OF-1:0] in_rise_en,
  input  logic [IO_NUM_OF-1:0] in_fall_en,
  input  logic                 in_ovf_clr,
  output logic                 out_evt_valid,
  input  logic                 in_evt_ready,
  output logic [IO_NUM_OF-1:0] out_evt_pins,
  output logic [TS_WIDTH-1:0]  out_evt_ts,
  output logic [IO_NUM_OF-1:0] out_pins_sync,
  output logic                 out_overflow
);

  localparam int EVT_W = evt_width(IO_NUM_OF, TS_WIDTH);
  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [1:0]     WARM_DONE = 2'(WARMUP_CYCLES);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

  logic [IO_NUM_OF-1:0] cur;
  logic [IO_NUM_OF-1:0] prev_q, prev_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [1:0]           warm_q, warm_d;
  logic                 warming;

  logic [EVT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [EVT_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d;

  logic [IO_NUM_OF-1:0] edge_r, edge_f;
  logic                 evt, empty, full, push, pop;

  assign warming = (warm_q != WARM_DONE);

  for (genvar i = 0; i < IO_NUM_OF; i++) begin : g_sync
    io_sync_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
      .in_clk  (in_clk),
      .in_rst_n(in_rst_n),
      .in_pin  (in_io_pins[i]),
      .in_warm (warming),
      .out_cur (cur[i])
    );
  end

  // Edge detection, event qualification and FIFO next state
  always_comb begin
    prev_d   = cur;
    ts_d     = ts_q + TS_WIDTH'(1);
    warm_d   = warming ? warm_q + 2'd1 : warm_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    edge_r = cur & ~prev_q & in_rise_en;
    edge_f = ~cur & prev_q & in_fall_en;
    evt    = (|(edge_r | edge_f)) && !warming;

    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
            (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop   = !empty && in_evt_ready;
    push  = evt && (!full || pop);

    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {cur, ts_q};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // A drop in the same cycle as a clear keeps the flag set
    if (in_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (evt && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // All sampler and FIFO state
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      prev_q   <= '0;
      ts_q     <= '0;
      warm_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      prev_q   <= prev_d;
      ts_q     <= ts_d;
      warm_q   <= warm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign out_evt_valid               = !empty;
  assign {out_evt_pins, out_evt_ts}  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign out_pins_sync               = cur;
  assign out_overflow                = ovf_q;

endmodule
